// File: rtl/hazard_detect_unit.sv
// Purpose : pipeline hazard detection (load-use, branch-after-load, HI/LO busy) driving stall/flush controls.
// Latency : STALL/FLUSH outputs are combinational from the current D/E/M state; MdBusy follows MdStart_E by one clock.
// Backpressure: none accepted; STALL is itself the backpressure to the front end (holds PC and IF/ID, bubbles ID/EX).
//
// Ports
//   CLK, RST_N                         sole clock; synchronous active-low reset
//   RsAddr_D, RtAddr_D, UseRs_D, UseRt_D   decode source registers and whether they are read
//   Branch_D, BranchTaken_D            decode holds beq/bne; branch resolved taken in D
//   RegDstAddr_E/M, MemRead_E/M        destination register and load flag in E and M
//   MdStart_E, MdStart_D, MdRead_D     mult/div issue in E; decode issues mult/div or reads HI/LO
//   PerfClr                            clears the performance counters
//   STALL, PcWriteEN, FLUSH_E, FLUSH_D, MdBusy   pipeline controls
//   StallCycles, FlushCount            performance counters
//
// Build option: define HAZARD_PERF_EN to include the StallCycles/FlushCount counters.
// Without it both counter outputs read 0 and PerfClr is ignored.
// MD_LATENCY legal range is 2..31 (counter is 5 bits wide).

module hazard_detect_unit #(
    parameter int MD_LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [4:0]  RsAddr_D,
    input  logic [4:0]  RtAddr_D,
    input  logic        UseRs_D,
    input  logic        UseRt_D,
    input  logic        Branch_D,
    input  logic        BranchTaken_D,
    input  logic [4:0]  RegDstAddr_E,
    input  logic [4:0]  RegDstAddr_M,
    input  logic        MemRead_E,
    input  logic        MemRead_M,
    input  logic        MdStart_E,
    input  logic        MdStart_D,
    input  logic        MdRead_D,
    input  logic        PerfClr,
    output logic        STALL,
    output logic        PcWriteEN,
    output logic        FLUSH_E,
    output logic        FLUSH_D,
    output logic        MdBusy,
    output logic [15:0] StallCycles,
    output logic [15:0] FlushCount
);

    localparam logic [4:0] MdReload = 5'(MD_LATENCY - 1);

    logic [4:0] mdCnt;
    logic       loadUse;
    logic       branchLoad;
    logic       mdHazard;
    logic       stallRaw;
    logic       mdBusyRaw;

    // HI/LO occupancy counter. A new issue reloads even while a previous
    // operation is still counting, since the newer result is what D waits on.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mdCnt <= 5'd0;
        end else if (MdStart_E) begin
            mdCnt <= MdReload;
        end else if (mdCnt != 5'd0) begin
            mdCnt <= mdCnt - 5'd1;
        end
    end

    always_comb begin
        mdBusyRaw = (mdCnt != 5'd0);

        // Load in E feeding a register D actually reads; $zero never carries a dependency.
        loadUse = MemRead_E && (RegDstAddr_E != 5'd0) &&
                  ((UseRs_D && (RegDstAddr_E == RsAddr_D)) ||
                   (UseRt_D && (RegDstAddr_E == RtAddr_D)));

        // Branches compare in D, so a load still in M cannot be forwarded in time.
        // Both operands of beq/bne are always read, hence no Use* qualification.
        branchLoad = Branch_D && MemRead_M && (RegDstAddr_M != 5'd0) &&
                     ((RegDstAddr_M == RsAddr_D) || (RegDstAddr_M == RtAddr_D));

        mdHazard = mdBusyRaw && (MdRead_D || MdStart_D);

        stallRaw = loadUse || branchLoad || mdHazard;
    end

    // Reset gating keeps every control output defined even while mdCnt is still
    // unknown before the first reset clock.
    always_comb begin
        STALL     = RST_N && stallRaw;
        PcWriteEN = !STALL;
        FLUSH_E   = STALL;
        // A stalled branch is squashed only once it can actually leave D.
        FLUSH_D   = RST_N && BranchTaken_D && !STALL;
        MdBusy    = RST_N && mdBusyRaw;
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stallCnt <= 16'd0;
            flushCnt <= 16'd0;
        end else if (PerfClr) begin
            stallCnt <= 16'd0;
            flushCnt <= 16'd0;
        end else begin
            if (STALL && (stallCnt != 16'hFFFF)) begin
                stallCnt <= stallCnt + 16'd1;
            end
            if (FLUSH_D && (flushCnt != 16'hFFFF)) begin
                flushCnt <= flushCnt + 16'd1;
            end
        end
    end

    assign StallCycles = stallCnt;
    assign FlushCount  = flushCnt;
`else
    logic unusedPerfClr;
    assign unusedPerfClr = PerfClr;
    assign StallCycles   = 16'd0;
    assign FlushCount    = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Purpose : exercises hazard_detect_unit against an event-level reference model.
// Latency : outputs sampled at the falling edge, model state advanced at the rising edge.
// Backpressure: not applicable; stimulus is driven every cycle.

module tb_hazard_detect_unit;

    localparam int MD_LATENCY = 4;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [4:0]  RsAddr_D = '0, RtAddr_D = '0, RegDstAddr_E = '0, RegDstAddr_M = '0;
    logic        UseRs_D = 0, UseRt_D = 0, Branch_D = 0, BranchTaken_D = 0;
    logic        MemRead_E = 0, MemRead_M = 0, MdStart_E = 0, MdStart_D = 0, MdRead_D = 0;
    logic        PerfClr = 0;
    logic        STALL, PcWriteEN, FLUSH_E, FLUSH_D, MdBusy;
    logic [15:0] StallCycles, FlushCount;
    logic [4:0]  dutVec;

    always #5 CLK = ~CLK;

    hazard_detect_unit #(.MD_LATENCY(MD_LATENCY)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .RsAddr_D(RsAddr_D), .RtAddr_D(RtAddr_D), .UseRs_D(UseRs_D), .UseRt_D(UseRt_D),
        .Branch_D(Branch_D), .BranchTaken_D(BranchTaken_D),
        .RegDstAddr_E(RegDstAddr_E), .RegDstAddr_M(RegDstAddr_M),
        .MemRead_E(MemRead_E), .MemRead_M(MemRead_M),
        .MdStart_E(MdStart_E), .MdStart_D(MdStart_D), .MdRead_D(MdRead_D),
        .PerfClr(PerfClr),
        .STALL(STALL), .PcWriteEN(PcWriteEN), .FLUSH_E(FLUSH_E), .FLUSH_D(FLUSH_D),
        .MdBusy(MdBusy), .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    // {STALL, PcWriteEN, FLUSH_E, FLUSH_D, MdBusy}
    assign dutVec = {STALL, PcWriteEN, FLUSH_E, FLUSH_D, MdBusy};

    int total = 0;
    int bad = 0;

    // Reference model: HI/LO busy is derived from how many cycles ago the last
    // multiply/divide issued; counters are plain integers clamped at 65535.
    int cycleNo = 0;
    int lastIssue = -1000;
    int stallModel = 0;
    int flushModel = 0;

    function automatic bit expMdBusy();
        int age;
        if (RST_N !== 1'b1) return 1'b0;
        age = cycleNo - lastIssue;
        return (age >= 1) && (age <= MD_LATENCY - 1);
    endfunction

    function automatic bit expStall();
        bit lu, bl, md;
        if (RST_N !== 1'b1) return 1'b0;
        lu = MemRead_E && (RegDstAddr_E != 0) &&
             ((UseRs_D && RegDstAddr_E == RsAddr_D) || (UseRt_D && RegDstAddr_E == RtAddr_D));
        bl = Branch_D && MemRead_M && (RegDstAddr_M != 0) &&
             (RegDstAddr_M == RsAddr_D || RegDstAddr_M == RtAddr_D);
        md = expMdBusy() && (MdRead_D || MdStart_D);
        return lu || bl || md;
    endfunction

    function automatic logic [4:0] expVec();
        bit s, f;
        s = expStall();
        f = (RST_N === 1'b1) && BranchTaken_D && !s;
        return {s, !s, s, f, expMdBusy()};
    endfunction

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic step();
        bit s, f;
        s = expStall();
        f = expVec()[1];
        @(posedge CLK);
        if (RST_N !== 1'b1) begin
            lastIssue  = -1000;
            stallModel = 0;
            flushModel = 0;
        end else begin
            if (MdStart_E) lastIssue = cycleNo;
            if (PERF) begin
                if (PerfClr) begin
                    stallModel = 0;
                    flushModel = 0;
                end else begin
                    if (s && stallModel < 65535) stallModel++;
                    if (f && flushModel < 65535) flushModel++;
                end
            end
        end
        cycleNo++;
        #1;
    endtask

    task automatic setIdle();
        RsAddr_D = 0; RtAddr_D = 0; UseRs_D = 0; UseRt_D = 0;
        Branch_D = 0; BranchTaken_D = 0;
        RegDstAddr_E = 0; RegDstAddr_M = 0; MemRead_E = 0; MemRead_M = 0;
        MdStart_E = 0; MdStart_D = 0; MdRead_D = 0; PerfClr = 0;
    endtask

    task automatic test_reset();
        RST_N = 0;
        MemRead_E = 1; RegDstAddr_E = 5'd7; RsAddr_D = 5'd7; UseRs_D = 1;
        BranchTaken_D = 1; MdStart_E = 1;
        @(negedge CLK);
        total++;
        if (dutVec !== 5'b01000) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected %b", dutVec, 5'b01000);
        end
        step();
        step();
        RST_N = 1;
        setIdle();
        @(negedge CLK);
        total++;
        if (dutVec !== 5'b01000) begin
            bad++;
            $display("FAIL after_reset_outputs: got %b expected %b", dutVec, 5'b01000);
        end
        total++;
        if (StallCycles !== 16'd0 || FlushCount !== 16'd0) begin
            bad++;
            $display("FAIL after_reset_counters: got %0d/%0d expected 0/0", StallCycles, FlushCount);
        end
        step();
    endtask

    task automatic test_load_use();
        setIdle();
        MemRead_E = 1; RegDstAddr_E = 5'd5; RsAddr_D = 5'd5; UseRs_D = 1;
        @(negedge CLK);
        total++;
        if (dutVec !== 5'b10100) begin
            bad++;
            $display("FAIL load_use_rs: got %b expected %b", dutVec, 5'b10100);
        end
        step();
        // Load has moved on; bubble now in E.
        MemRead_E = 0; RegDstAddr_E = 0;
        @(negedge CLK);
        total++;
        if (dutVec !== 5'b01000) begin
            bad++;
            $display("FAIL load_use_release: got %b expected %b", dutVec, 5'b01000);
        end
        step();
        MemRead_E = 1; RegDstAddr_E = 5'd5; RsAddr_D = 5'd5; UseRs_D = 0;
        @(negedge CLK);
        total++;
        if (dutVec !== 5'b01000) begin
            bad++;
            $display("FAIL load_use_rs_unused: got %b expected %b", dutVec, 5'b01000);
        end
        step();
        RsAddr_D = 5'd1; RtAddr_D = 5'd5; UseRt_D = 1;
        @(negedge CLK);
        total++;
        if (dutVec !== 5'b10100) begin
            bad++;
            $display("FAIL load_use_rt: got %b expected %b", dutVec, 5'b10100);
        end
        step();
        setIdle();
    endtask

    task automatic test_branch_load();
        logic [4:0] expSeq [3];
        expSeq[0] = 5'b10100;
        expSeq[1] = 5'b10100;
        expSeq[2] = 5'b01010;
        setIdle();
        for (int i = 0; i < 3; i++) begin
            Branch_D = 1; BranchTaken_D = 1; RsAddr_D = 5'd8; RtAddr_D = 5'd9;
            UseRs_D = 1; UseRt_D = 1;
            MemRead_E = (i == 0); RegDstAddr_E = (i == 0) ? 5'd8 : 5'd0;
            MemRead_M = (i == 1); RegDstAddr_M = (i == 1) ? 5'd8 : 5'd0;
            @(negedge CLK);
            total++;
            if (dutVec !== expSeq[i]) begin
                bad++;
                $display("FAIL branch_load_cycle%0d: got %b expected %b", i, dutVec, expSeq[i]);
            end
            step();
        end
        setIdle();
    endtask

    task automatic test_md();
        setIdle();
        MdStart_E = 1;
        @(negedge CLK);
        total++;
        if (dutVec !== 5'b01000) begin
            bad++;
            $display("FAIL md_issue_cycle: got %b expected %b", dutVec, 5'b01000);
        end
        step();
        MdStart_E = 0; MdRead_D = 1;
        for (int i = 0; i < 4; i++) begin
            logic [4:0] e;
            e = (i < 3) ? 5'b10101 : 5'b01000;
            @(negedge CLK);
            total++;
            if (dutVec !== e) begin
                bad++;
                $display("FAIL md_busy_cycle%0d: got %b expected %b", i + 1, dutVec, e);
            end
            step();
        end
        setIdle();
    endtask

    task automatic test_zero_priority();
        setIdle();
        MemRead_E = 1; RegDstAddr_E = 5'd0; RsAddr_D = 5'd0; UseRs_D = 1;
        @(negedge CLK);
        total++;
        if (dutVec !== 5'b01000) begin
            bad++;
            $display("FAIL zero_reg: got %b expected %b", dutVec, 5'b01000);
        end
        step();
        RegDstAddr_E = 5'd3; RsAddr_D = 5'd3; Branch_D = 1; BranchTaken_D = 1;
        @(negedge CLK);
        total++;
        if (dutVec !== 5'b10100) begin
            bad++;
            $display("FAIL stall_over_flush: got %b expected %b", dutVec, 5'b10100);
        end
        step();
        MemRead_E = 0; RegDstAddr_E = 0;
        @(negedge CLK);
        total++;
        if (dutVec !== 5'b01010) begin
            bad++;
            $display("FAIL flush_after_stall: got %b expected %b", dutVec, 5'b01010);
        end
        step();
        setIdle();
    endtask

    task automatic test_reset_midcount();
        setIdle();
        MdStart_E = 1;
        step();
        MdStart_E = 0; MdRead_D = 1;
        step();
        @(negedge CLK);
        total++;
        if (dutVec !== 5'b10101) begin
            bad++;
            $display("FAIL midcount_busy: got %b expected %b", dutVec, 5'b10101);
        end
        total++;
        if (StallCycles !== 16'(stallModel)) begin
            bad++;
            $display("FAIL midcount_stallcycles: got %0d expected %0d", StallCycles, stallModel);
        end
        RST_N = 0;
        step();
        RST_N = 1;
        @(negedge CLK);
        total++;
        if (dutVec !== 5'b01000) begin
            bad++;
            $display("FAIL midcount_reset_outputs: got %b expected %b", dutVec, 5'b01000);
        end
        total++;
        if (StallCycles !== 16'd0) begin
            bad++;
            $display("FAIL midcount_reset_stallcycles: got %0d expected 0", StallCycles);
        end
        step();
        setIdle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            RST_N         = ($urandom_range(0, 199) != 0);
            RsAddr_D      = 5'($urandom_range(0, 3));
            RtAddr_D      = 5'($urandom_range(0, 3));
            RegDstAddr_E  = 5'($urandom_range(0, 3));
            RegDstAddr_M  = 5'($urandom_range(0, 3));
            UseRs_D       = 1'($urandom_range(0, 1));
            UseRt_D       = 1'($urandom_range(0, 1));
            Branch_D      = 1'($urandom_range(0, 1));
            BranchTaken_D = 1'($urandom_range(0, 1));
            MemRead_E     = 1'($urandom_range(0, 1));
            MemRead_M     = 1'($urandom_range(0, 1));
            MdStart_E     = ($urandom_range(0, 9) == 0);
            MdStart_D     = ($urandom_range(0, 9) < 3);
            MdRead_D      = ($urandom_range(0, 9) < 3);
            PerfClr       = ($urandom_range(0, 99) == 0);
            @(negedge CLK);
            total++;
            if (dutVec !== expVec()) begin
                bad++;
                $display("FAIL rand_controls cycle %0d: got %b expected %b", n, dutVec, expVec());
            end
            total++;
            if (StallCycles !== 16'(stallModel)) begin
                bad++;
                $display("FAIL rand_stallcycles cycle %0d: got %0d expected %0d", n, StallCycles, stallModel);
            end
            total++;
            if (FlushCount !== 16'(flushModel)) begin
                bad++;
                $display("FAIL rand_flushcount cycle %0d: got %0d expected %0d", n, FlushCount, flushModel);
            end
            step();
        end
        RST_N = 1;
        setIdle();
        step();
    endtask

    task automatic test_saturation();
        setIdle();
        PerfClr = 1;
        step();
        PerfClr = 0;
        MemRead_E = 1; RegDstAddr_E = 5'd4; RtAddr_D = 5'd4; UseRt_D = 1;
`ifdef HAZARD_PERF_EN
        repeat (65540) step();
        @(negedge CLK);
        total++;
        if (StallCycles !== 16'hFFFF || stallModel != 65535) begin
            bad++;
            $display("FAIL stall_saturate: got %h expected ffff", StallCycles);
        end
        PerfClr = 1;
        step();
        PerfClr = 0;
        @(negedge CLK);
        total++;
        if (StallCycles !== 16'd0) begin
            bad++;
            $display("FAIL perfclr_over_increment: got %0d expected 0", StallCycles);
        end
`else
        repeat (20) step();
        @(negedge CLK);
        total++;
        if (StallCycles !== 16'd0 || FlushCount !== 16'd0) begin
            bad++;
            $display("FAIL counters_tied_off: got %0d/%0d expected 0/0", StallCycles, FlushCount);
        end
`endif
        step();
        setIdle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load();
        test_md();
        test_zero_priority();
        test_reset_midcount();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_detect_unit.md
HAZARD_DETECT_UNIT -- requirements
Module: hazard_detect_unit

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4, legal 2..31: cycles a multiply/divide occupies the HI/LO unit after issue from E.
REQ-002 SHALL have port CLK  in  1  rising-edge clock, sole clock.
REQ-003 SHALL have port RST_N  in  1  reset; synchronous, active-low.
REQ-004 SHALL have ports RsAddr_D, RtAddr_D  in  5 each  decode-stage source register numbers.
REQ-005 SHALL have ports UseRs_D, UseRt_D  in  1 each  decode instruction actually reads Rs/Rt.
REQ-006 SHALL have ports Branch_D  in  1  (decode holds beq/bne) and BranchTaken_D  in  1  (branch resolved taken in D).
REQ-007 SHALL have ports RegDstAddr_E, RegDstAddr_M  in  5 each  and MemRead_E, MemRead_M  in  1 each  (load in that stage).
REQ-008 SHALL have ports MdStart_E  in  1  (mult/div issuing in E), MdStart_D, MdRead_D  in  1 each  (decode issues mult/div, or reads HI/LO).
REQ-009 SHALL have port PerfClr  in  1  synchronous clear of performance counters.
REQ-010 SHALL have outputs STALL  1  (hold PC and IF/ID; to forwarding unit), PcWriteEN  1, FLUSH_E  1  (bubble into ID/EX), FLUSH_D  1  (squash IF/ID), MdBusy  1.
REQ-011 SHALL have outputs StallCycles  16  and FlushCount  16  performance counters.

Function
REQ-012 SHALL raise load-use hazard LU when MemRead_E, RegDstAddr_E!=0, and (UseRs_D and RegDstAddr_E==RsAddr_D) or (UseRt_D and RegDstAddr_E==RtAddr_D).
REQ-013 SHALL raise branch-load hazard BL when Branch_D, MemRead_M, RegDstAddr_M!=0 and RegDstAddr_M equals RsAddr_D or RtAddr_D; BL plus LU gives 2 stall cycles for a branch right after its load.
REQ-014 SHALL hold a 5-bit down-counter MdCnt; MdBusy = (MdCnt!=0).
REQ-015 SHALL load MdCnt with MD_LATENCY-1 on a cycle with MdStart_E=1, including when MdCnt is nonzero (reload wins over decrement).
REQ-016 SHALL otherwise decrement MdCnt by 1 per cycle while nonzero; no wrap below 0.
REQ-017 SHALL raise MD hazard when MdBusy and (MdRead_D or MdStart_D).
REQ-018 SHALL drive STALL = LU or BL or MD, combinationally in the same cycle, valid (never X) whenever RST_N=1.
REQ-019 SHALL drive PcWriteEN = not STALL and FLUSH_E = STALL.
REQ-020 SHALL drive FLUSH_D = BranchTaken_D and not STALL; the stall takes priority and the branch is re-evaluated when the stall clears.
REQ-021 SHALL increment StallCycles on each clock where STALL=1 and FlushCount on each clock where FLUSH_D=1, saturating at 16'hFFFF.
REQ-022 SHALL clear both counters on a clock with PerfClr=1; clear wins over a same-cycle increment.

Reset
REQ-023 SHALL, on a clock edge with RST_N=0, clear MdCnt, StallCycles and FlushCount.
REQ-024 SHALL force STALL=0, FLUSH_E=0, FLUSH_D=0, PcWriteEN=1 and MdBusy=0 while RST_N=0.
REQ-025 SHALL abandon an in-flight mult/div count on reset mid-operation; MdBusy=0 on the first cycle after RST_N returns high.

Configuration
REQ-026 SHALL compile the performance counters (REQ-021, REQ-022) only when macro HAZARD_PERF_EN is defined.
REQ-027 SHALL, without HAZARD_PERF_EN, keep ports StallCycles, FlushCount and PerfClr, tie both counter outputs to 0, ignore PerfClr, and instantiate no counter flops.

Verification
REQ-028 SHALL cover load-use: MemRead_E=1, RegDstAddr_E=5, RsAddr_D=5, UseRs_D=1 -> STALL=1, FLUSH_E=1, PcWriteEN=0 for exactly that cycle; same with UseRs_D=0 -> STALL=0.
REQ-029 SHALL cover branch after load: lw $8, then beq $8 in D -> STALL=1 for 2 consecutive cycles (LU, then BL), then FLUSH_D=1 if BranchTaken_D=1.
REQ-030 SHALL cover mult/div: MD_LATENCY=4, MdStart_E pulse then MdRead_D held -> MdBusy=1 for 3 cycles, STALL=1 for those 3 cycles, STALL=0 on the 4th.
REQ-031 SHALL cover $zero and priority: RegDstAddr_E=0 with MemRead_E=1 and RsAddr_D=0 -> STALL=0; BranchTaken_D=1 during LU -> FLUSH_D=0.
REQ-032 SHALL cover reset mid-count: RST_N=0 for one clock at MdCnt=2 -> MdBusy=0 and, with HAZARD_PERF_EN, StallCycles=0 afterwards.
REQ-033 SHALL cover saturation: with HAZARD_PERF_EN, 65540 stall cycles -> StallCycles=16'hFFFF; PerfClr=1 -> 0 on the next clock.
